// File: rtl/s1_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : s1_rr_arbiter_pkg
// Brief    : Shared types and constants for the S1 round-robin arbiter.
// Revision : 1.0
// ============================================================================
package s1_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam int         NREQ    = 4;
    localparam logic [1:0] PTR_RST = 2'd3;

endpackage : s1_rr_arbiter_pkg
`default_nettype wire

// File: rtl/mux4to1.sv
`default_nettype none
// ============================================================================
// Module   : mux4to1
// Brief    : Four-input N-bit multiplexer, shared S-cell datapath select.
// Revision : 1.0
// ============================================================================
module mux4to1 #(
    parameter int N = 8
) (
    input  logic [1:0]   i_sel,
    input  logic [N-1:0] i_d0,
    input  logic [N-1:0] i_d1,
    input  logic [N-1:0] i_d2,
    input  logic [N-1:0] i_d3,
    output logic [N-1:0] o_y
);

    always_comb begin
        o_y = i_d0;
        case (i_sel)
            2'd0:    o_y = i_d0;
            2'd1:    o_y = i_d1;
            2'd2:    o_y = i_d2;
            default: o_y = i_d3;
        endcase
    end

endmodule : mux4to1
`default_nettype wire

// File: rtl/s1_rr_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : s1_rr_arbiter_pick
// Brief    : Combinational round-robin pick, searching from i_ptr+1 upward.
// Revision : 1.0
// ============================================================================
module s1_rr_arbiter_pick
    import s1_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic [1:0]      i_ptr,
    output logic [1:0]      o_sel,
    output logic            o_any
);

    logic [1:0] w_idx;

    always_comb begin
        o_sel = 2'd0;
        o_any = 1'b0;
        w_idx = 2'd0;
        // Last-granted requester is searched last (k=4 wraps back to i_ptr).
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = i_ptr + 2'(k);
            if (!o_any && i_req[w_idx]) begin
                o_sel = w_idx;
                o_any = 1'b1;
            end
        end
    end

endmodule : s1_rr_arbiter_pick
`default_nettype wire

// File: rtl/s1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : s1_rr_arbiter
// Brief    : Round-robin sequencer for the shared 4:1 mux + output register.
// Revision : 1.0
// ============================================================================
module s1_rr_arbiter
    import s1_rr_arbiter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            flush,
    input  logic [NREQ-1:0] req,
    input  logic [N-1:0]    d0,
    input  logic [N-1:0]    d1,
    input  logic [N-1:0]    d2,
    input  logic [N-1:0]    d3,
    output logic [NREQ-1:0] ack,
    output logic [N-1:0]    out,
    output logic [1:0]      out_id,
    output logic            out_valid,
    input  logic            out_ready
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_ptr;
    logic [N-1:0] r_out;
    logic [1:0]   r_out_id;

    logic [1:0]   w_sel;
    logic         w_any;
    logic         w_load;
    logic [N-1:0] w_mux;

    s1_rr_arbiter_pick u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    mux4to1 #(.N(N)) u_mux (
        .i_sel (w_sel),
        .i_d0  (d0),
        .i_d1  (d1),
        .i_d2  (d2),
        .i_d3  (d3),
        .o_y   (w_mux)
    );

    // A FULL register that is being drained can be reloaded on the same edge.
    assign w_load = w_any && !flush && ((r_state == IDLE) || out_ready);

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else if (w_load) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && out_ready) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state  <= IDLE;
            r_ptr    <= PTR_RST;
            r_out    <= '0;
            r_out_id <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_ptr    <= w_sel;
                r_out    <= w_mux;
                r_out_id <= w_sel;
            end
        end
    end

    assign ack       = (w_load && clr_n) ? (4'b0001 << w_sel) : 4'b0000;
    assign out       = r_out;
    assign out_id    = r_out_id;
    assign out_valid = (r_state == FULL);

endmodule : s1_rr_arbiter
`default_nettype wire

// File: tb/tb_s1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_s1_rr_arbiter
// Brief    : Directed self-checking bench for s1_rr_arbiter.
// Revision : 1.0
// ============================================================================
module tb_s1_rr_arbiter;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       flush;
    logic [3:0] req;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] ack;
    logic [7:0] out;
    logic [1:0] out_id;
    logic       out_valid;
    logic       out_ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    s1_rr_arbiter #(.N(8)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .ack       (ack),
        .out       (out),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp_d;
        clr_n = 1'b0; flush = 1'b0; req = 4'b1111; out_ready = 1'b1;
        d0 = 8'h10; d1 = 8'h11; d2 = 8'h12; d3 = 8'h13;
        #1;
        n_total++; if (out !== 8'h00) $display("FAIL reset_out: got %h expected 00", out); else n_pass++;
        n_total++; if (out_id !== 2'd0) $display("FAIL reset_id: got %0d expected 0", out_id); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (ack !== 4'b0000) $display("FAIL reset_ack: got %b expected 0000", ack); else n_pass++;
        step();
        clr_n = 1'b1;
        #1;
        n_total++; if (ack !== 4'b0001) $display("FAIL reset_first_ack: got %b expected 0001", ack); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_d = 8'h10 + 8'(i);
            n_total++; if (out_valid !== 1'b1) $display("FAIL reset_seq_valid[%0d]: got %b expected 1", i, out_valid); else n_pass++;
            n_total++; if (out_id !== 2'(i)) $display("FAIL reset_seq_id[%0d]: got %0d expected %0d", i, out_id, i); else n_pass++;
            n_total++; if (out !== exp_d) $display("FAIL reset_seq_out[%0d]: got %h expected %h", i, out, exp_d); else n_pass++;
        end
        req = 4'b0000;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_drain_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out !== 8'h13) $display("FAIL reset_drain_out: got %h expected 13", out); else n_pass++;
    endtask

    // ptr=3 on entry; leaves ptr=2, IDLE.
    task automatic test_single();
        out_ready = 1'b0; req = 4'b0100; d2 = 8'hA5;
        #1;
        n_total++; if (ack !== 4'b0100) $display("FAIL single_ack: got %b expected 0100", ack); else n_pass++;
        step();
        req = 4'b0000;
        #1;
        n_total++; if (out !== 8'hA5) $display("FAIL single_out: got %h expected a5", out); else n_pass++;
        n_total++; if (out_id !== 2'd2) $display("FAIL single_id: got %0d expected 2", out_id); else n_pass++;
        n_total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++; if (out_valid !== 1'b1 || out !== 8'hA5 || ack !== 4'b0000)
                $display("FAIL single_hold[%0d]: got v=%b out=%h ack=%b expected v=1 out=a5 ack=0000", i, out_valid, out, ack);
            else n_pass++;
        end
        out_ready = 1'b1;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %b expected 0", out_valid); else n_pass++;
    endtask

    // Moves ptr to 1, then req=1001 held: grants 3,0,3,0. Leaves ptr=0.
    task automatic test_rr_order();
        logic [1:0] exp_id [4];
        exp_id = '{2'd3, 2'd0, 2'd3, 2'd0};
        out_ready = 1'b1; req = 4'b0010;
        #1;
        n_total++; if (ack !== 4'b0010) $display("FAIL rr_setup_ack: got %b expected 0010", ack); else n_pass++;
        step();
        req = 4'b0000;
        step();
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++; if (ack !== (4'b0001 << exp_id[i])) $display("FAIL rr_ack[%0d]: got %b expected grant %0d", i, ack, exp_id[i]); else n_pass++;
            step();
            n_total++; if (out_id !== exp_id[i]) $display("FAIL rr_id[%0d]: got %0d expected %0d", i, out_id, exp_id[i]); else n_pass++;
        end
        req = 4'b0000;
        step();
    endtask

    // ptr=0: req=0011 alternates 1,0,1,0,... every cycle. Leaves ptr=0.
    task automatic test_back_to_back();
        logic [1:0] exp_id;
        logic [7:0] exp_d;
        d0 = 8'h20; d1 = 8'h21; out_ready = 1'b1; req = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            step();
            exp_id = (i % 2 == 0) ? 2'd1 : 2'd0;
            exp_d  = (i % 2 == 0) ? 8'h21 : 8'h20;
            n_total++; if (out_valid !== 1'b1 || out_id !== exp_id || out !== exp_d)
                $display("FAIL b2b[%0d]: got v=%b id=%0d out=%h expected v=1 id=%0d out=%h", i, out_valid, out_id, out, exp_id, exp_d);
            else n_pass++;
        end
        req = 4'b0000;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", out_valid); else n_pass++;
    endtask

    // ptr=0 on entry; leaves ptr=1, IDLE.
    task automatic test_backpressure();
        d0 = 8'h30; d1 = 8'h31; out_ready = 1'b0; req = 4'b0001;
        #1;
        n_total++; if (ack !== 4'b0001) $display("FAIL bp_load_ack: got %b expected 0001", ack); else n_pass++;
        step();
        req = 4'b0010;
        #1;
        n_total++; if (ack !== 4'b0000) $display("FAIL bp_stall_ack: got %b expected 0000", ack); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            n_total++; if (out !== 8'h30 || out_id !== 2'd0 || out_valid !== 1'b1)
                $display("FAIL bp_hold[%0d]: got out=%h id=%0d v=%b expected out=30 id=0 v=1", i, out, out_id, out_valid);
            else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_total++; if (ack !== 4'b0010) $display("FAIL bp_release_ack: got %b expected 0010", ack); else n_pass++;
        n_total++; if (out !== 8'h30) $display("FAIL bp_release_out: got %h expected 30", out); else n_pass++;
        step();
        req = 4'b0000;
        n_total++; if (out !== 8'h31 || out_id !== 2'd1 || out_valid !== 1'b1)
            $display("FAIL bp_new: got out=%h id=%0d v=%b expected out=31 id=1 v=1", out, out_id, out_valid);
        else n_pass++;
        step();
    endtask

    // ptr=1 on entry.
    task automatic test_async_reset_flush();
        d2 = 8'h5A; out_ready = 1'b0; req = 4'b0100;
        step();
        req = 4'b0000;
        n_total++; if (out_valid !== 1'b1) $display("FAIL ar_pre_valid: got %b expected 1", out_valid); else n_pass++;
        #2 clr_n = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL ar_valid_drop: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out !== 8'h00) $display("FAIL ar_out_clear: got %h expected 00", out); else n_pass++;
        #1 clr_n = 1'b1;
        // ptr=3 now: load d2 to reach FULL with ptr=2.
        d2 = 8'h66; req = 4'b0100;
        step();
        req = 4'b0000;
        flush = 1'b1; req = 4'b0001;
        #1;
        n_total++; if (ack !== 4'b0000) $display("FAIL flush_ack: got %b expected 0000", ack); else n_pass++;
        step();
        flush = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (out !== 8'h66 || out_id !== 2'd2) $display("FAIL flush_data: got out=%h id=%0d expected out=66 id=2", out, out_id); else n_pass++;
        // ptr retained at 2: search order 3,0,1 picks 0 for req=0011.
        req = 4'b0011;
        #1;
        n_total++; if (ack !== 4'b0001) $display("FAIL flush_ptr: got ack %b expected 0001", ack); else n_pass++;
        req = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr_order();
        test_back_to_back();
        test_backpressure();
        test_async_reset_flush();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_s1_rr_arbiter
`default_nettype wire
